// File: rtl/hsv_to_rgb_conv.sv
// hsv_to_rgb_conv: five-stage pipelined HSV-to-RGB converter.
// One pixel per clock, fixed latency of five clocks. The valid flag and the
// sync sideband ride alongside the pixel data through the same five stages.
module hsv_to_rgb_conv #(
    parameter int SB_W = 3
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            valid_in,
    input  logic [SB_W-1:0] sb_in,
    input  logic [8:0]      H_in,
    input  logic [10:0]     S_in,
    input  logic [7:0]      V_in,
    output logic            valid_out,
    output logic [SB_W-1:0] sb_out,
    output logic [7:0]      R_out,
    output logic [7:0]      G_out,
    output logic [7:0]      B_out
);

    typedef enum logic [2:0] {
        SEC0 = 3'd0,
        SEC1 = 3'd1,
        SEC2 = 3'd2,
        SEC3 = 3'd3,
        SEC4 = 3'd4,
        SEC5 = 3'd5
    } sector_t;

    // floor(y/60) == (y * 17477) >> 20 holds exactly for every y <= 15075,
    // since the reciprocal overshoot (44/2^20 per unit) stays below 1/60.
    localparam logic [27:0] RECIP_60 = 28'd17477;

    // Control pipeline: valid flags and sideband, one entry per stage.
    logic [4:0]           valid_pipe;
    logic [4:0][SB_W-1:0] sb_pipe;

    // Stage 1 results
    sector_t     sec1;
    logic [5:0]  f1;
    logic [18:0] vs1;
    logic [7:0]  v1;

    // Stage 2 results
    sector_t     sec2;
    logic [5:0]  f2;
    logic [7:0]  c2;
    logic [7:0]  m2;
    logic [7:0]  v2;

    // Stage 3 results
    sector_t     sec3;
    logic [13:0] cf3;
    logic [7:0]  m3;
    logic [7:0]  v3;

    // Stage 4 results
    sector_t     sec4;
    logic [7:0]  rise4;
    logic [7:0]  fall4;
    logic [7:0]  m4;
    logic [7:0]  v4;

    // Combinational intermediates
    logic [8:0]  hue_n;
    logic [8:0]  hue_base;
    sector_t     sec_c;
    logic [5:0]  f_c;
    logic [18:0] c_sum;
    logic [7:0]  c_c;
    logic [14:0] cf_round;
    logic [27:0] q_prod;
    logic [7:0]  q_c;
    logic [7:0]  r_c;
    logic [7:0]  g_c;
    logic [7:0]  b_c;

    // Hue normalisation and sector/fraction split by a compare chain.
    always_comb begin
        // NOTE: every signal written here gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        hue_n    = H_in;
        hue_base = 9'd0;
        sec_c    = SEC0;
        if (H_in >= 9'd360) begin
            hue_n = H_in - 9'd360;
        end
        if (hue_n >= 9'd300) begin
            sec_c    = SEC5;
            hue_base = 9'd300;
        end else if (hue_n >= 9'd240) begin
            sec_c    = SEC4;
            hue_base = 9'd240;
        end else if (hue_n >= 9'd180) begin
            sec_c    = SEC3;
            hue_base = 9'd180;
        end else if (hue_n >= 9'd120) begin
            sec_c    = SEC2;
            hue_base = 9'd120;
        end else if (hue_n >= 9'd60) begin
            sec_c    = SEC1;
            hue_base = 9'd60;
        end
        f_c = 6'(hue_n - hue_base);
    end

    // Chroma rounding and reciprocal-multiply division for q.
    always_comb begin
        c_sum    = vs1 + 19'd1024;
        c_c      = 8'(c_sum >> 11);
        cf_round = 15'(cf3) + 15'd30;
        q_prod   = 28'(cf_round) * RECIP_60;
        q_c      = 8'(q_prod >> 20);
    end

    // Per-sector selection of V / rise / fall / m onto R, G, B.
    always_comb begin
        r_c = v4;
        g_c = m4;
        b_c = m4;
        case (sec4)
            SEC0: begin r_c = v4;    g_c = rise4; b_c = m4;    end
            SEC1: begin r_c = fall4; g_c = v4;    b_c = m4;    end
            SEC2: begin r_c = m4;    g_c = v4;    b_c = rise4; end
            SEC3: begin r_c = m4;    g_c = fall4; b_c = v4;    end
            SEC4: begin r_c = rise4; g_c = m4;    b_c = v4;    end
            SEC5: begin r_c = v4;    g_c = m4;    b_c = fall4; end
            default: begin r_c = v4; g_c = m4;    b_c = m4;    end
        endcase
    end

    // Valid and sideband delay line; cleared at once by reset so no stale
    // pixel is ever flagged valid after a mid-stream reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_pipe <= '0;
            sb_pipe    <= '0;
        end else begin
            // NOTE: non-blocking assignments let every stage sample the
            // previous stage's old value, forming a true shift register.
            valid_pipe <= {valid_pipe[3:0], valid_in};
            sb_pipe    <= {sb_pipe[3:0], sb_in};
        end
    end

    // Data path stages 1-4; qualified by valid_pipe, so no reset needed.
    always_ff @(posedge clk) begin
        // NOTE: data registers are deliberately left unreset; the valid flag
        // alone decides whether their contents mean anything.
        sec1  <= sec_c;
        f1    <= f_c;
        vs1   <= V_in * S_in;
        v1    <= V_in;

        sec2  <= sec1;
        f2    <= f1;
        c2    <= c_c;
        m2    <= v1 - c_c;
        v2    <= v1;

        sec3  <= sec2;
        cf3   <= 14'(c2) * 14'(f2);
        m3    <= m2;
        v3    <= v2;

        sec4  <= sec3;
        rise4 <= m3 + q_c;
        fall4 <= v3 - q_c;
        m4    <= m3;
        v4    <= v3;
    end

    // Stage 5 output registers, cleared by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            R_out <= '0;
            G_out <= '0;
            B_out <= '0;
        end else begin
            R_out <= r_c;
            G_out <= g_c;
            B_out <= b_c;
        end
    end

    assign valid_out = valid_pipe[4];
    assign sb_out    = sb_pipe[4];

endmodule
